blake_state_writeback: RTL

Owns the 16×64-bit BLAKE-512 working state V and the step/round counter for the 1G core. It loads the initial V, then accepts each G-function result and writes the four output words back to the V positions used by that step. Its `v_out` and `counter_idx` drive `blake_state_mux` combinationally, closing the per-step compression loop, and it signals completion after the final step.

---
 rtl/blake_pkg.sv | 30 +++
 rtl/blake_step_decode.sv | 20 ++
 rtl/blake_state_writeback.sv | 90 +++++++++
 3 files changed

// File: rtl/blake_pkg.sv
// Shared BLAKE-512 constants: word/counter widths, FSM encoding and the
// per-step V word-index table used by both the write-back block and the mux.
package blake_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned NWORDS = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned V_W    = WORD_W * NWORDS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // {a,b,c,d} word indices per step; steps 0..3 columns, 4..7 diagonals
    localparam logic [7:0][4*IDX_W-1:0] STEP_WORD_IDX = {
        16'h349E,   // s7: V3  V4  V9  V14
        16'h278D,   // s6: V2  V7  V8  V13
        16'h16BC,   // s5: V1  V6  V11 V12
        16'h05AF,   // s4: V0  V5  V10 V15
        16'h37BF,   // s3
        16'h26AE,   // s2
        16'h159D,   // s1
        16'h048C    // s0
    };

endpackage

// File: rtl/blake_step_decode.sv
// Maps a G step (0..7) to the four V word indices written for a, b, c, d.
module blake_step_decode
    import blake_pkg::*;
(
    input  logic [STEP_W-1:0] i_step,
    output logic [IDX_W-1:0]  o_idx_a_c,
    output logic [IDX_W-1:0]  o_idx_b_c,
    output logic [IDX_W-1:0]  o_idx_c_c,
    output logic [IDX_W-1:0]  o_idx_d_c
);

    logic [4*IDX_W-1:0] w_entry;

    assign w_entry   = STEP_WORD_IDX[i_step];
    assign o_idx_a_c = w_entry[4*IDX_W-1 -: IDX_W];
    assign o_idx_b_c = w_entry[3*IDX_W-1 -: IDX_W];
    assign o_idx_c_c = w_entry[2*IDX_W-1 -: IDX_W];
    assign o_idx_d_c = w_entry[IDX_W-1   -: IDX_W];

endmodule

// File: rtl/blake_state_writeback.sv
// BLAKE-512 working-state register and step/round counter: loads V, writes
// back each G result to its step's four words and pulses done after the last step.
module blake_state_writeback
    import blake_pkg::*;
#(
    parameter int unsigned ROUNDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [V_W-1:0]    v_init,
    input  logic              g_valid,
    input  logic [WORD_W-1:0] a_out,
    input  logic [WORD_W-1:0] b_out,
    input  logic [WORD_W-1:0] c_out,
    input  logic [WORD_W-1:0] d_out,
    output logic [V_W-1:0]    v_out,
    output logic [CNT_W-1:0]  counter_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(8 * ROUNDS - 1);

    // Element 15 holds V0 so the packed vector matches the bus layout directly
    logic [NWORDS-1:0][WORD_W-1:0] r_v;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_busy;
    logic                          r_done;
    state_t                        r_state;

    logic [IDX_W-1:0] w_idx_a;
    logic [IDX_W-1:0] w_idx_b;
    logic [IDX_W-1:0] w_idx_c;
    logic [IDX_W-1:0] w_idx_d;

    blake_step_decode u_step_decode (
        .i_step    (r_cnt[STEP_W-1:0]),
        .o_idx_a_c (w_idx_a),
        .o_idx_b_c (w_idx_b),
        .o_idx_c_c (w_idx_c),
        .o_idx_d_c (w_idx_d)
    );

    // init restarts from any state and overrides a coincident g_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_done <= 1'b0;
            if (init) begin
                r_v     <= v_init;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (g_valid) begin
                            r_v[IDX_W'(4'd15 - w_idx_a)] <= a_out;
                            r_v[IDX_W'(4'd15 - w_idx_b)] <= b_out;
                            r_v[IDX_W'(4'd15 - w_idx_c)] <= c_out;
                            r_v[IDX_W'(4'd15 - w_idx_d)] <= d_out;
                            if (r_cnt == LAST_IDX) begin
                                r_cnt   <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_cnt <= CNT_W'(r_cnt + 1'b1);
                            end
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign v_out       = r_v;
    assign counter_idx = r_cnt;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
